lsu_mem_mux: RTL and testbench
==============================

LSU_MEM_MUX -- requirements
Module: lsu_mem_mux

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 16: number of requesting lanes.
REQ-002 SHALL have parameter ADDR_W, default 32: request address width.
REQ-003 SHALL have parameter DATA_W, default 32: write/read data width.
REQ-004 SHALL have parameter MAX_OUTST, default 4: maximum outstanding reads (power of two, >=2).
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req_valid_i  input  NUM_PORTS  per-lane request valid.
REQ-008 req_ready_o  output  NUM_PORTS  per-lane accept; at most one bit high per cycle.
REQ-009 req_we_i  input  NUM_PORTS  per-lane write enable (1 = write, 0 = read).
REQ-010 req_addr_i  input  NUM_PORTS*ADDR_W  packed lane addresses; lane k at [k*ADDR_W +: ADDR_W].
REQ-011 req_wdata_i  input  NUM_PORTS*DATA_W  packed lane write data.
REQ-012 mem_req_valid_o / mem_req_ready_i  output / input  1 / 1  memory request handshake.
REQ-013 mem_req_we_o, mem_req_addr_o, mem_req_wdata_o  output  1, ADDR_W, DATA_W  forwarded request.
REQ-014 mem_rsp_valid_i, mem_rsp_data_i  input  1, DATA_W  in-order read response; no backpressure.
REQ-015 rsp_valid_o  output  NUM_PORTS  one-hot read-response strobe to the originating lane.
REQ-016 rsp_data_o  output  DATA_W  read data, broadcast to all lanes.
REQ-017 err_o  output  1  sticky: response received with no outstanding read.

Function
REQ-018 Lane k transfer SHALL occur when req_valid_i[k] && req_ready_o[k]; the lane holds valid and payload stable until accepted.
REQ-019 Grant SHALL be round-robin: highest priority is the lowest-index valid lane above the last accepted lane, wrapping to lane 0; after reset, lane 0 is highest.
REQ-020 req_ready_o[k] SHALL be high only for the granted lane, and only when the output register is empty or is being drained in the same cycle, and (for reads) the route FIFO is not full.
REQ-021 An accepted request SHALL appear on mem_req_* on the next cycle (1-cycle latency) and stay stable until mem_req_ready_i.
REQ-022 The output register SHALL have states EMPTY and FULL: EMPTY->FULL on accept; FULL->EMPTY on memory handshake with no new accept; FULL->FULL on a simultaneous handshake and accept, giving one request per cycle sustained.
REQ-023 On a read accept, the lane index SHALL be pushed into the route FIFO; a write SHALL push nothing.
REQ-024 On mem_rsp_valid_i with a non-empty FIFO, the head SHALL be popped; rsp_valid_o[head] and rsp_data_o SHALL be registered and appear one cycle later for exactly one cycle.
REQ-025 A simultaneous push and pop SHALL be legal at any occupancy, including full: occupancy is unchanged.
REQ-026 When MAX_OUTST reads are outstanding, reads SHALL be blocked; writes from the granted lane SHALL still be accepted.
REQ-027 If the granted lane is a blocked read, the grant SHALL still advance to the next valid lane (no head-of-line lockup).
REQ-028 mem_rsp_valid_i with an empty FIFO SHALL be dropped and SHALL set err_o until reset.

Reset
REQ-029 Reset SHALL clear req_ready_o, mem_req_valid_o, rsp_valid_o, and err_o, empty the route FIFO, and set the last-granted pointer to NUM_PORTS-1.
REQ-030 mem_req_addr_o, mem_req_wdata_o, mem_req_we_o, and rsp_data_o SHALL reset to 0.
REQ-031 Reset mid-transaction SHALL abandon in-flight requests and outstanding reads without producing a response strobe.

Configuration
REQ-032 With LSU_MEM_MUX_STATS_EN defined, output stall_cnt_o (32 bits) SHALL count cycles where mem_req_valid_o && !mem_req_ready_i, wrapping, reset to 0.
REQ-033 Without the macro, stall_cnt_o and its counter SHALL be absent.

Structure
REQ-034 Package lsu_mem_pkg SHALL hold the port-index typedef (clog2 NUM_PORTS) and the mem-request struct (we, addr, wdata).
REQ-035 Sub-module lsu_route_fifo SHALL implement the MAX_OUTST-deep index FIFO with full/empty and push/pop.

Verification
REQ-036 Lanes 3 and 7 valid (reads), mem_req_ready_i=1 -> accepts 3, 7, 3, 7 on consecutive cycles; mem_req_addr_o follows one cycle later.
REQ-037 Lane 5 read, then hold mem_req_ready_i=0 for 4 cycles -> mem_req_* stable, req_ready_o=0, stall_cnt_o=4 (macro on).
REQ-038 Lanes 2, 9, 15, 0 issue reads; responses D0..D3 -> rsp_valid_o one-hot 2, 9, 15, 0 in order, each one cycle after its response.
REQ-039 Five reads with no responses (MAX_OUTST=4) -> fifth blocked; lane 6 write accepted meanwhile; first response unblocks the fifth read.
REQ-040 Response with FIFO empty -> no rsp_valid_o; err_o=1 and stays 1 until reset.
REQ-041 Reset asserted with 2 reads outstanding -> all outputs 0; later responses set err_o; next grant goes to lane 0.

Source files
------------

// File: rtl/lsu_mem_pkg.sv
// Shared types and defaults for the LSU memory multiplexer.
// The port-index and request types here describe the default configuration.
package lsu_mem_pkg;

  localparam int unsigned LsuNumPorts = 16;
  localparam int unsigned LsuAddrW    = 32;
  localparam int unsigned LsuDataW    = 32;
  localparam int unsigned LsuMaxOutst = 4;

  // Index width for n lanes; a single lane still needs one bit to carry an index.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [$clog2(LsuNumPorts)-1:0] port_idx_t;

  typedef struct packed {
    logic                we;
    logic [LsuAddrW-1:0] addr;
    logic [LsuDataW-1:0] wdata;
  } mem_req_t;

  typedef enum logic {OutEmpty, OutFull} out_state_e;

endpackage

// File: rtl/lsu_route_fifo.sv
// Lane-index FIFO that remembers which lane owns each outstanding read.
// Push and pop in the same cycle are legal at any occupancy, including full.
module lsu_route_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/lsu_mem_mux.sv
// Round-robin multiplexer of NUM_PORTS load/store lanes onto one memory port with
// in-order read routing. Define LSU_MEM_MUX_STATS_EN to add the stall_cnt_o counter.
module lsu_mem_mux
  import lsu_mem_pkg::*;
#(
  parameter int unsigned NUM_PORTS = LsuNumPorts,
  parameter int unsigned ADDR_W    = LsuAddrW,
  parameter int unsigned DATA_W    = LsuDataW,
  parameter int unsigned MAX_OUTST = LsuMaxOutst
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid_i,
  output logic [NUM_PORTS-1:0]        req_ready_o,
  input  logic [NUM_PORTS-1:0]        req_we_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata_i,
  output logic                        mem_req_valid_o,
  input  logic                        mem_req_ready_i,
  output logic                        mem_req_we_o,
  output logic [ADDR_W-1:0]           mem_req_addr_o,
  output logic [DATA_W-1:0]           mem_req_wdata_o,
  input  logic                        mem_rsp_valid_i,
  input  logic [DATA_W-1:0]           mem_rsp_data_i,
  output logic [NUM_PORTS-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_data_o,
`ifdef LSU_MEM_MUX_STATS_EN
  output logic [31:0]                 stall_cnt_o,
`endif
  output logic                        err_o
);

  localparam int unsigned IdxW = idx_w(NUM_PORTS);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  out_state_e           state_q;
  req_t                 out_q, sel_req;
  logic [IdxW-1:0]      last_q, grant, cand, fifo_head;
  logic                 grant_vld, out_full, can_accept, read_blocked, accept;
  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [NUM_PORTS-1:0] rsp_valid_q;
  logic [DATA_W-1:0]    rsp_data_q;
  logic                 err_q;

  // Lowest-index valid lane above the last granted one, wrapping around.
  always_comb begin
    grant     = last_q;
    grant_vld = 1'b0;
    cand      = last_q;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand = IdxW'((32'(last_q) + i) % NUM_PORTS);
      if (!grant_vld && req_valid_i[cand]) begin
        grant     = cand;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_req = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (grant == IdxW'(k)) begin
        sel_req.we    = req_we_i[k];
        sel_req.addr  = req_addr_i[k*ADDR_W +: ADDR_W];
        sel_req.wdata = req_wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign out_full     = (state_q == OutFull);
  assign can_accept   = !out_full || mem_req_ready_i;
  assign read_blocked = !sel_req.we && fifo_full;
  assign accept       = grant_vld && can_accept && !read_blocked && !reset;
  assign req_ready_o  = accept ? (NUM_PORTS'(1) << grant) : '0;

  assign fifo_push = accept && !sel_req.we;
  assign fifo_pop  = mem_rsp_valid_i && !fifo_empty;

  lsu_route_fifo #(
    .DEPTH(MAX_OUTST),
    .WIDTH(IdxW)
  ) u_route_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(grant),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= OutEmpty;
      out_q       <= '0;
      last_q      <= IdxW'(NUM_PORTS - 1);
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        state_q <= OutFull;
        out_q   <= sel_req;
      end else if (out_full && mem_req_ready_i) begin
        state_q <= OutEmpty;
      end
      // A blocked read still passes priority on so other lanes are not starved.
      if (grant_vld && (accept || read_blocked)) last_q <= grant;
      rsp_valid_q <= fifo_pop ? (NUM_PORTS'(1) << fifo_head) : '0;
      if (fifo_pop) rsp_data_q <= mem_rsp_data_i;
      if (mem_rsp_valid_i && fifo_empty) err_q <= 1'b1;
    end
  end

`ifdef LSU_MEM_MUX_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (out_full && !mem_req_ready_i) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign mem_req_valid_o = out_full;
  assign mem_req_we_o    = out_q.we;
  assign mem_req_addr_o  = out_q.addr;
  assign mem_req_wdata_o = out_q.wdata;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_data_o      = rsp_data_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_lsu_mem_mux.sv
// Scoreboard-based bench for lsu_mem_mux: expected memory requests and lane responses
// are queued as stimulus is driven and compared when the design produces them.
module tb_lsu_mem_mux;

  localparam int NP = 16;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     req_valid_i, req_ready_o, req_we_i, rsp_valid_o;
  logic [NP*AW-1:0]  req_addr_i;
  logic [NP*DW-1:0]  req_wdata_i;
  logic              mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
  logic [AW-1:0]     mem_req_addr_o;
  logic [DW-1:0]     mem_req_wdata_o, mem_rsp_data_i, rsp_data_o;
  logic              mem_rsp_valid_i, err_o;
`ifdef LSU_MEM_MUX_STATS_EN
  logic [31:0]       stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [AW+DW:0] exp_req[$];
  int             exp_rsp_lane[$];
  logic [DW-1:0]  exp_rsp_data[$];
  logic [AW+DW:0] e_req;
  int             e_lane;
  logic [DW-1:0]  e_data;

  always #5 clk = ~clk;

  lsu_mem_mux #(
    .NUM_PORTS(NP),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_OUTST(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_req_we_o   (mem_req_we_o),
    .mem_req_addr_o (mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o),
    .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i (mem_rsp_data_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_data_o     (rsp_data_o),
`ifdef LSU_MEM_MUX_STATS_EN
    .stall_cnt_o    (stall_cnt_o),
`endif
    .err_o          (err_o)
  );

  function automatic logic [AW-1:0] lane_addr(int k);
    return 32'hA000_0000 + 32'(k) * 32'h10;
  endfunction

  function automatic logic [DW-1:0] lane_wdata(int k);
    return 32'h5500_0000 + 32'(k);
  endfunction

  // Memory-side and lane-side scoreboards.
  always @(negedge clk) begin
    if (!reset && mem_req_valid_o && mem_req_ready_i) begin
      checks++;
      if (exp_req.size() == 0) begin
        errors++;
        $display("FAIL mem_req_unexpected: got addr %h, expected no request", mem_req_addr_o);
      end else begin
        e_req = exp_req.pop_front();
        if ({mem_req_we_o, mem_req_addr_o, mem_req_wdata_o} !== e_req) begin
          errors++;
          $display("FAIL mem_req: got %h, expected %h",
                   {mem_req_we_o, mem_req_addr_o, mem_req_wdata_o}, e_req);
        end
      end
    end
    if (!reset && rsp_valid_o != '0) begin
      checks++;
      if (exp_rsp_lane.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got strobe %h, expected none", rsp_valid_o);
      end else begin
        e_lane = exp_rsp_lane.pop_front();
        e_data = exp_rsp_data.pop_front();
        if (rsp_valid_o !== (NP'(1) << e_lane) || rsp_data_o !== e_data) begin
          errors++;
          $display("FAIL rsp: got strobe %h data %h, expected strobe %h data %h",
                   rsp_valid_o, rsp_data_o, NP'(1) << e_lane, e_data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected to finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(int k);
    exp_req.push_back({req_we_i[k], lane_addr(k), lane_wdata(k)});
  endtask

  task automatic push_rsp(int k, logic [DW-1:0] d);
    exp_rsp_lane.push_back(k);
    exp_rsp_data.push_back(d);
  endtask

  task automatic do_reset;
    reset           = 1'b1;
    req_valid_i     = '0;
    req_we_i        = '0;
    mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    exp_req.delete();
    exp_rsp_lane.delete();
    exp_rsp_data.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset;
    reset       = 1'b1;
    req_valid_i = '1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== '0 || mem_req_valid_o !== 1'b0 || rsp_valid_o !== '0) begin
      errors++;
      $display("FAIL reset_valids: ready %h memv %b rspv %h, expected all 0",
               req_ready_o, mem_req_valid_o, rsp_valid_o);
    end
    checks++;
    if (err_o !== 1'b0 || mem_req_we_o !== 1'b0 || mem_req_addr_o !== '0 ||
        mem_req_wdata_o !== '0 || rsp_data_o !== '0) begin
      errors++;
      $display("FAIL reset_data: err %b we %b addr %h wdata %h rdata %h, expected all 0",
               err_o, mem_req_we_o, mem_req_addr_o, mem_req_wdata_o, rsp_data_o);
    end
    do_reset;
    req_valid_i = 16'h8001;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 16'h0001) begin
      errors++;
      $display("FAIL reset_first_grant: got %h, expected %h", req_ready_o, 16'h0001);
    end
    push_req(0);
    tick;
    req_valid_i = '0;
    tick;
  endtask

  task automatic test_round_robin;
    int lane;
    do_reset;
    req_valid_i[3] = 1'b1;
    req_valid_i[7] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lane = (i % 2 == 0) ? 3 : 7;
      @(negedge clk);
      checks++;
      if (req_ready_o !== (NP'(1) << lane)) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %h, expected %h", i, req_ready_o, NP'(1) << lane);
      end
      push_req(lane);
      tick;
    end
    @(negedge clk);
    checks++;
    if (req_ready_o !== '0) begin
      errors++;
      $display("FAIL rr_fifo_full: got %h, expected 0", req_ready_o);
    end
    tick;
    req_valid_i = '0;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = 32'hD000_0000 + 32'(i);
      push_rsp((i % 2 == 0) ? 3 : 7, mem_rsp_data_i);
      tick;
    end
    mem_rsp_valid_i = 1'b0;
    repeat (2) tick;
  endtask

  task automatic test_stall;
    do_reset;
    mem_req_ready_i = 1'b0;
    req_valid_i[5]  = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 16'h0020) begin
      errors++;
      $display("FAIL stall_accept: got %h, expected %h", req_ready_o, 16'h0020);
    end
    push_req(5);
    tick;
    req_valid_i    = '0;
    req_valid_i[1] = 1'b1;
    req_we_i[1]    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready_o !== '0 || mem_req_valid_o !== 1'b1 ||
          {mem_req_we_o, mem_req_addr_o, mem_req_wdata_o} !== {1'b0, lane_addr(5), lane_wdata(5)}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: ready %h memv %b addr %h, expected 0 1 %h",
                 i, req_ready_o, mem_req_valid_o, mem_req_addr_o, lane_addr(5));
      end
      tick;
    end
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 16'h0002) begin
      errors++;
      $display("FAIL stall_drain_accept: got %h, expected %h", req_ready_o, 16'h0002);
    end
    push_req(1);
`ifdef LSU_MEM_MUX_STATS_EN
    checks++;
    if (stall_cnt_o !== 32'd4) begin
      errors++;
      $display("FAIL stall_cnt: got %0d, expected 4", stall_cnt_o);
    end
`endif
    tick;
    req_valid_i = '0;
    req_we_i    = '0;
    tick;
    @(negedge clk);
    checks++;
    if (mem_req_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_empty: got %b, expected 0", mem_req_valid_o);
    end
  endtask

  task automatic test_order;
    int lanes [4];
    lanes = '{2, 9, 15, 0};
    do_reset;
    for (int i = 0; i < 4; i++) begin
      req_valid_i           = '0;
      req_valid_i[lanes[i]] = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready_o !== (NP'(1) << lanes[i])) begin
        errors++;
        $display("FAIL order_accept[%0d]: got %h, expected %h",
                 i, req_ready_o, NP'(1) << lanes[i]);
      end
      push_req(lanes[i]);
      tick;
    end
    req_valid_i = '0;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = 32'hC0DE_0000 + 32'(i);
      push_rsp(lanes[i], mem_rsp_data_i);
      @(negedge clk);
      checks++;
      if (rsp_valid_o !== '0) begin
        errors++;
        $display("FAIL order_idle[%0d]: got %h, expected 0", i, rsp_valid_o);
      end
      tick;
      mem_rsp_valid_i = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid_o !== (NP'(1) << lanes[i]) || rsp_data_o !== 32'hC0DE_0000 + 32'(i)) begin
        errors++;
        $display("FAIL order_rsp[%0d]: got %h/%h, expected %h/%h", i, rsp_valid_o, rsp_data_o,
                 NP'(1) << lanes[i], 32'hC0DE_0000 + 32'(i));
      end
      tick;
    end
    @(negedge clk);
    checks++;
    if (rsp_valid_o !== '0) begin
      errors++;
      $display("FAIL order_final_idle: got %h, expected 0", rsp_valid_o);
    end
  endtask

  task automatic test_outstanding;
    int drain [4];
    drain = '{2, 3, 4, 8};
    do_reset;
    for (int k = 1; k <= 4; k++) begin
      req_valid_i    = '0;
      req_valid_i[k] = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready_o !== (NP'(1) << k)) begin
        errors++;
        $display("FAIL outst_accept[%0d]: got %h, expected %h", k, req_ready_o, NP'(1) << k);
      end
      push_req(k);
      tick;
    end
    req_valid_i    = '0;
    req_valid_i[8] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== '0) begin
      errors++;
      $display("FAIL outst_fifth_blocked: got %h, expected 0", req_ready_o);
    end
    tick;
    req_valid_i[6] = 1'b1;
    req_we_i[6]    = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 16'h0040) begin
      errors++;
      $display("FAIL outst_write_pass: got %h, expected %h", req_ready_o, 16'h0040);
    end
    push_req(6);
    tick;
    req_valid_i[6] = 1'b0;
    req_we_i[6]    = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready_o !== '0) begin
      errors++;
      $display("FAIL outst_still_blocked: got %h, expected 0", req_ready_o);
    end
    tick;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'hE000_0001;
    push_rsp(1, mem_rsp_data_i);
    @(negedge clk);
    checks++;
    if (req_ready_o !== '0) begin
      errors++;
      $display("FAIL outst_rsp_cycle: got %h, expected 0", req_ready_o);
    end
    tick;
    mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 16'h0100) begin
      errors++;
      $display("FAIL outst_unblock: got %h, expected %h", req_ready_o, 16'h0100);
    end
    push_req(8);
    tick;
    req_valid_i = '0;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = 32'hE100_0000 + 32'(i);
      push_rsp(drain[i], mem_rsp_data_i);
      tick;
    end
    mem_rsp_valid_i = 1'b0;
    repeat (2) tick;
  endtask

  task automatic test_err;
    do_reset;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'hBAD0_0001;
    @(negedge clk);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL err_before: got %b, expected 0", err_o);
    end
    tick;
    mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1 || rsp_valid_o !== '0) begin
      errors++;
      $display("FAIL err_set: err %b rspv %h, expected 1 0", err_o, rsp_valid_o);
    end
    repeat (3) tick;
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b, expected 1", err_o);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    req_valid_i[10] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 16'h0400) begin
      errors++;
      $display("FAIL rmid_accept10: got %h, expected %h", req_ready_o, 16'h0400);
    end
    push_req(10);
    tick;
    req_valid_i     = '0;
    req_valid_i[11] = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 16'h0800) begin
      errors++;
      $display("FAIL rmid_accept11: got %h, expected %h", req_ready_o, 16'h0800);
    end
    push_req(11);
    tick;
    req_valid_i = '0;
    reset       = 1'b1;
    exp_req.delete();
    exp_rsp_lane.delete();
    exp_rsp_data.delete();
    @(negedge clk);
    checks++;
    if (req_ready_o !== '0 || mem_req_valid_o !== 1'b0 || rsp_valid_o !== '0 ||
        err_o !== 1'b0 || mem_req_addr_o !== '0) begin
      errors++;
      $display("FAIL rmid_cleared: ready %h memv %b rspv %h err %b addr %h, expected all 0",
               req_ready_o, mem_req_valid_o, rsp_valid_o, err_o, mem_req_addr_o);
    end
    repeat (2) tick;
    reset           = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = 32'hF00D_0000;
    req_valid_i     = 16'h0021;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 16'h0001) begin
      errors++;
      $display("FAIL rmid_grant_lane0: got %h, expected %h", req_ready_o, 16'h0001);
    end
    push_req(0);
    tick;
    mem_rsp_valid_i = 1'b0;
    req_valid_i     = '0;
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1 || rsp_valid_o !== '0) begin
      errors++;
      $display("FAIL rmid_stale_rsp: err %b rspv %h, expected 1 0", err_o, rsp_valid_o);
    end
    repeat (2) tick;
  endtask

  initial begin
    reset           = 1'b1;
    req_valid_i     = '0;
    req_we_i        = '0;
    mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    for (int k = 0; k < NP; k++) begin
      req_addr_i[k*AW +: AW]  = lane_addr(k);
      req_wdata_i[k*DW +: DW] = lane_wdata(k);
    end
    test_reset;
    test_round_robin;
    test_stall;
    test_order;
    test_outstanding;
    test_err;
    test_reset_mid;
    checks++;
    if (exp_req.size() != 0) begin
      errors++;
      $display("FAIL req_scoreboard_drain: %0d left, expected 0", exp_req.size());
    end
    checks++;
    if (exp_rsp_lane.size() != 0) begin
      errors++;
      $display("FAIL rsp_scoreboard_drain: %0d left, expected 0", exp_rsp_lane.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
